// File: rtl/morra_giocatore.sv
// morra_giocatore: plays both sides of a Morra Cinese (rock-paper-scissors) match against the
// game block. It starts the game and passes it the match-length code. It then generates legal
// move pairs from an LFSR and tallies the round results the game reports. The match ends on the
// game's final verdict or on a timeout, and the outcome is reported to the host.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start, cfg, seed  host request, match-length code (rounds = cfg + 4), LFSR seed
//   primo, secondo    player moves to the game (01 rock, 10 paper, 11 scissors, 00 none)
//   inizio            game start strobe (carries cfg on primo/secondo)
//   manche, partita   round / match result from the game (01 p1, 10 p2, 11 draw, 00 none)
//   busy, done        match in progress / one-cycle end-of-match pulse
//   risultato, errore final match result and timeout flag, held until the next start
//   giocate, vinte1, vinte2, pari   rounds played and per-outcome tallies
module morra_giocatore #(
    parameter int unsigned TIMEOUT      = 8,
    parameter logic [7:0]  SEED_DEFAULT = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cfg,
    input  logic [7:0] seed,
    output logic [1:0] primo,
    output logic [1:0] secondo,
    output logic       inizio,
    input  logic [1:0] manche,
    input  logic [1:0] partita,
    output logic       busy,
    output logic       done,
    output logic [1:0] risultato,
    output logic       errore,
    output logic [4:0] giocate,
    output logic [4:0] vinte1,
    output logic [4:0] vinte2,
    output logic [4:0] pari
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StConfig, StGap, StMossa, StVerifica, StDrena, StFine
    } state_e;

    state_e           state;
    logic [7:0]       lfsr;
    logic [1:0]       last_win;   // 01 p1, 10 p2, 00 none
    logic [1:0]       vietata;    // move the last winner may not play again
    logic [4:0]       limite;
    logic [CntW-1:0]  attesa;

    logic [7:0] lfsr_next;
    logic [1:0] win_eff, viet_eff;
    logic [1:0] cand1, cand2;

    // Fibonacci LFSR, taps 8,6,5,4
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    function automatic logic [1:0] ruota(input logic [1:0] m);
        case (m)
            2'b01:   ruota = 2'b10;
            2'b10:   ruota = 2'b11;
            default: ruota = 2'b01;
        endcase
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] x);
        sat_inc = (x == 5'd31) ? x : x + 5'd1;
    endfunction

    // The pair chosen when leaving VERIFICA must already honour the result sampled this cycle,
    // so the winner/forbidden information is bypassed here before it is registered.
    always_comb begin
        win_eff  = last_win;
        viet_eff = vietata;
        if (state == StVerifica) begin
            case (manche)
                2'b01: begin
                    win_eff  = 2'b01;
                    viet_eff = primo;
                end
                2'b10: begin
                    win_eff  = 2'b10;
                    viet_eff = secondo;
                end
                2'b11:   win_eff = 2'b00;
                default: ;
            endcase
        end
    end

    always_comb begin
        cand1 = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
        cand2 = (lfsr[3:2] == 2'b00) ? 2'b01 : lfsr[3:2];
        if (win_eff == 2'b01 && cand1 == viet_eff) cand1 = ruota(cand1);
        if (win_eff == 2'b10 && cand2 == viet_eff) cand2 = ruota(cand2);
    end

    // Outputs are registered: each transition loads the values of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            lfsr      <= SEED_DEFAULT;
            last_win  <= 2'b00;
            vietata   <= 2'b00;
            limite    <= 5'd0;
            attesa    <= '0;
            primo     <= 2'b00;
            secondo   <= 2'b00;
            inizio    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            risultato <= 2'b00;
            errore    <= 1'b0;
            giocate   <= 5'd0;
            vinte1    <= 5'd0;
            vinte2    <= 5'd0;
            pari      <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        lfsr      <= (seed == 8'h00) ? SEED_DEFAULT : seed;
                        // a fresh match starts with no forbidden move
                        last_win  <= 2'b00;
                        vietata   <= 2'b00;
                        limite    <= {1'b0, cfg} + 5'd4;
                        giocate   <= 5'd0;
                        vinte1    <= 5'd0;
                        vinte2    <= 5'd0;
                        pari      <= 5'd0;
                        risultato <= 2'b00;
                        errore    <= 1'b0;
                        busy      <= 1'b1;
                        inizio    <= 1'b1;
                        primo     <= cfg[3:2];
                        secondo   <= cfg[1:0];
                        state     <= StConfig;
                    end else begin
                        inizio  <= 1'b0;
                        primo   <= 2'b00;
                        secondo <= 2'b00;
                    end
                end
                StConfig: begin
                    inizio  <= 1'b0;
                    primo   <= 2'b00;
                    secondo <= 2'b00;
                    state   <= StGap;
                end
                StGap: begin
                    primo   <= cand1;
                    secondo <= cand2;
                    lfsr    <= lfsr_next;
                    state   <= StMossa;
                end
                StMossa: state <= StVerifica;
                StVerifica: begin
                    last_win <= win_eff;
                    vietata  <= viet_eff;
                    case (manche)
                        2'b01:   vinte1 <= sat_inc(vinte1);
                        2'b10:   vinte2 <= sat_inc(vinte2);
                        2'b11:   pari   <= sat_inc(pari);
                        default: ;
                    endcase
                    if (manche != 2'b00) giocate <= sat_inc(giocate);
                    if (partita != 2'b00) begin
                        risultato <= partita;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StFine;
                    end else if (manche == 2'b00) begin
                        // no verdict: replay the held pair, LFSR untouched
                        state <= StMossa;
                    end else if (sat_inc(giocate) == limite) begin
                        primo   <= 2'b00;
                        secondo <= 2'b00;
                        attesa  <= CntW'(1);
                        state   <= StDrena;
                    end else begin
                        primo   <= cand1;
                        secondo <= cand2;
                        lfsr    <= lfsr_next;
                        state   <= StMossa;
                    end
                end
                StDrena: begin
                    if (partita != 2'b00) begin
                        risultato <= partita;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StFine;
                    end else if (attesa == CntW'(TIMEOUT)) begin
                        errore    <= 1'b1;
                        risultato <= 2'b00;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StFine;
                    end else begin
                        attesa <= attesa + 1'b1;
                    end
                end
                StFine: begin
                    primo   <= 2'b00;
                    secondo <= 2'b00;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_morra_giocatore.sv
// Self-checking bench for morra_giocatore: table of match scenarios driven through one task,
// with a reference move generator feeding a scoreboard queue of expected move pairs.
module tb_morra_giocatore;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset, start, inizio, busy, done, errore;
    logic [3:0] cfg;
    logic [7:0] seed;
    logic [1:0] manche, partita, primo, secondo, risultato;
    logic [4:0] giocate, vinte1, vinte2, pari;

    always #5 clk = ~clk;

    morra_giocatore #(.TIMEOUT(TIMEOUT), .SEED_DEFAULT(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg(cfg), .seed(seed),
        .primo(primo), .secondo(secondo), .inizio(inizio), .manche(manche), .partita(partita),
        .busy(busy), .done(done), .risultato(risultato), .errore(errore), .giocate(giocate),
        .vinte1(vinte1), .vinte2(vinte2), .pari(pari)
    );

    typedef struct {
        logic [3:0] cfg;
        logic [7:0] seed;
        int         fin_round;   // played round whose VERIFICA sees partita (0: never)
        int         drain_part;  // DRENA cycle in which partita appears (0: never)
        logic [1:0] fin_val;
        int         zero_round;  // VERIFICA index answered with manche 00 (0: none)
        bit         force_p1;    // game always reports p1 winning
        int         abort_at;    // DRENA cycle in which reset is asserted (0: none)
        bit         hold_start;
        int         exp_giocate;
        bit         exp_err;
        logic [1:0] exp_ris;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_lfsr;
    logic [1:0] m_lw, m_forb;
    int         m_g, m_v1, m_v2, m_p;
    logic [3:0] exp_q[$];
    vec_t       vecs[8];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic outs_zero(input string name);
        check(name, {primo, secondo, inizio, busy, done, risultato, errore,
                     giocate, vinte1, vinte2, pari}, 0);
    endtask

    function automatic logic [1:0] outcome(input logic [1:0] a, input logic [1:0] b);
        if (a == b) return 2'b11;
        if ((a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10) ||
            (a == 2'b01 && b == 2'b11)) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [1:0] next_move(input logic [1:0] m);
        return (m == 2'b11) ? 2'b01 : m + 2'b01;
    endfunction

    // Reference generator: expected pair from the model LFSR, then one LFSR step.
    task automatic model_push();
        logic [1:0] c1, c2;
        logic       fb;
        c1 = (m_lfsr[1:0] == 2'b00) ? 2'b01 : m_lfsr[1:0];
        c2 = (m_lfsr[3:2] == 2'b00) ? 2'b01 : m_lfsr[3:2];
        if (m_lw == 2'b01 && c1 == m_forb) c1 = next_move(c1);
        if (m_lw == 2'b10 && c2 == m_forb) c2 = next_move(c2);
        exp_q.push_back({c1, c2});
        fb     = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
    endtask

    task automatic reset_dut();
        reset = 1'b1; start = 1'b0; manche = 2'b00; partita = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_match(input vec_t v);
        int         limit, verif, ending;
        bit         just_zero;
        logic [3:0] ep;
        logic [1:0] res, prev_p1;
        reset_dut();
        m_lfsr = (v.seed == 8'h00) ? 8'hA5 : v.seed;
        m_lw = 2'b00; m_forb = 2'b00;
        m_g = 0; m_v1 = 0; m_v2 = 0; m_p = 0;
        exp_q.delete();
        limit = int'(v.cfg) + 4;
        cfg = v.cfg; seed = v.seed; start = 1'b1;
        tick();
        check("config_inizio", inizio, 1);
        check("config_moves", {primo, secondo}, v.cfg);
        check("config_busy", busy, 1);
        check("config_clear", {risultato, errore, giocate}, 0);
        if (!v.hold_start) start = 1'b0;
        tick();
        check("gap_idle_moves", {inizio, primo, secondo}, 0);
        model_push();
        verif = 0; ending = 0; just_zero = 1'b0; prev_p1 = 2'b00;
        while (ending == 0) begin
            tick();
            if (exp_q.size() == 0 || verif > 64) begin
                bound_expired("round_loop");
                return;
            end
            ep = exp_q.pop_front();
            check("mossa_pair", {primo, secondo}, ep);
            check("mossa_nonzero", {primo != 2'b00, secondo != 2'b00}, 2'b11);
            if (v.force_p1 && m_g > 0 && !just_zero) check("winner_no_repeat", primo != prev_p1, 1);
            check("mossa_tally", {giocate, vinte1, vinte2, pari},
                  {m_g[4:0], m_v1[4:0], m_v2[4:0], m_p[4:0]});
            tick();
            check("verifica_hold", {primo, secondo}, ep);
            verif++;
            if (verif == v.zero_round) begin
                res = 2'b00; manche = 2'b00;
            end else if (v.force_p1) begin
                res = 2'b01; manche = 2'b01;
            end else begin
                res = outcome(ep[3:2], ep[1:0]); manche = outcome(primo, secondo);
            end
            partita = 2'b00;
            just_zero = (res == 2'b00);
            if (res != 2'b00) begin
                m_g++;
                prev_p1 = ep[3:2];
                case (res)
                    2'b01: begin m_v1++; m_lw = 2'b01; m_forb = ep[3:2]; end
                    2'b10: begin m_v2++; m_lw = 2'b10; m_forb = ep[1:0]; end
                    default: begin m_p++; m_lw = 2'b00; end
                endcase
            end
            if (res != 2'b00 && m_g == v.fin_round) begin
                partita = v.fin_val; ending = 1;
            end else if (res == 2'b00) begin
                exp_q.push_back(ep);
            end else if (m_g == limit) begin
                ending = 2;
            end else begin
                model_push();
            end
        end
        tick();
        manche = 2'b00;
        if (ending == 2) begin
            for (int d = 1; d <= TIMEOUT; d++) begin
                if (d > 1) tick();
                check("drena_moves", {primo, secondo, inizio}, 0);
                check("drena_done_busy", {done, busy}, 2'b01);
                if (v.abort_at == d) begin
                    reset = 1'b1; start = 1'b1;
                    tick();
                    outs_zero("abort_outs");
                    tick();
                    outs_zero("abort_outs_held");
                    reset = 1'b0;
                    tick();
                    check("release_inizio", {inizio, primo, secondo}, {1'b1, v.cfg});
                    start = 1'b0;
                    return;
                end
                if (v.drain_part == d) begin
                    partita = v.fin_val;
                    break;
                end
            end
            tick();
        end
        check("fine_done_busy", {done, busy}, 2'b10);
        check("fine_risultato", risultato, v.exp_ris);
        check("fine_errore", errore, v.exp_err);
        check("fine_giocate", giocate, v.exp_giocate);
        check("fine_tally", {vinte1, vinte2, pari}, {m_v1[4:0], m_v2[4:0], m_p[4:0]});
        partita = 2'b00;
        tick();
        check("idle_done", done, 0);
        check("idle_held", {risultato, errore}, {v.exp_ris, v.exp_err});
        check("idle_moves", {inizio, primo, secondo}, 0);
        if (v.hold_start) begin
            tick();
            check("restart_inizio", inizio, 1);
            check("restart_clear", {busy, risultato, errore}, 4'b1000);
            start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //               cfg    seed   fin drn val    zero frc abrt hold  giocate err ris
        vecs[0] = '{4'd6,  8'h3C, 3, 0, 2'b01, 0, 1'b0, 0, 1'b0, 3,  1'b0, 2'b01};
        vecs[1] = '{4'd2,  8'h00, 0, 3, 2'b10, 0, 1'b0, 0, 1'b0, 6,  1'b0, 2'b10};
        vecs[2] = '{4'd1,  8'h5A, 4, 0, 2'b11, 2, 1'b0, 0, 1'b0, 4,  1'b0, 2'b11};
        vecs[3] = '{4'd15, 8'h81, 0, 0, 2'b00, 0, 1'b1, 0, 1'b0, 19, 1'b1, 2'b00};
        vecs[4] = '{4'd0,  8'h01, 0, 0, 2'b00, 0, 1'b0, 0, 1'b0, 4,  1'b1, 2'b00};
        vecs[5] = '{4'd0,  8'h77, 4, 0, 2'b10, 0, 1'b0, 0, 1'b0, 4,  1'b0, 2'b10};
        vecs[6] = '{4'd0,  8'hC3, 0, 0, 2'b00, 0, 1'b0, 3, 1'b0, 0,  1'b0, 2'b00};
        vecs[7] = '{4'd3,  8'h2B, 2, 0, 2'b01, 0, 1'b0, 0, 1'b1, 2,  1'b0, 2'b01};

        // Reset with start held: nothing moves until reset is released.
        reset = 1'b1; start = 1'b1; cfg = 4'b0110; seed = 8'h00;
        manche = 2'b00; partita = 2'b00;
        tick();
        tick();
        outs_zero("reset_outs");
        tick();
        check("reset_no_inizio", inizio, 0);
        reset = 1'b0;
        tick();
        check("release_inizio", {inizio, primo, secondo}, 5'b1_0110);
        start = 1'b0;
        tick();
        check("inizio_one_cycle", {inizio, primo, secondo}, 0);

        for (int i = 0; i < 8; i++) run_match(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
